// File: rtl/div_mon_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | div_mon_pkg : state encoding and default constants for the         |
// |               divided-clock monitor.  Rev 1.0                      |
// +--------------------------------------------------------------------+
package div_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACQ  = 2'd1,
      ST_LOCK = 2'd2
   } state_e;

   localparam int c_def_exp_half   = 2;
   localparam int c_def_cnt_w      = 8;
   localparam int c_def_lock_count = 4;
   localparam int c_def_timeout    = 16;

endpackage
`default_nettype wire

// File: rtl/div_clock_monitor_edge_detect.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | edge_detect : registered rise/fall pulses of a same-domain level,  |
// |               plus the unregistered rise for same-cycle use. Rev 1.0|
// +--------------------------------------------------------------------+
module edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic rise_now,
   output logic rise,
   output logic fall
);
   logic d1_q, d1_d;
   logic rise_q, rise_d;
   logic fall_q, fall_d;

   always_comb begin
      d1_d   = din;
      rise_d = din & ~d1_q;
      fall_d = ~din & d1_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         d1_q   <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         d1_q   <= d1_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign rise_now = rise_d;
   assign rise     = rise_q;
   assign fall     = fall_q;

endmodule
`default_nettype wire

// File: rtl/div_clock_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | div_clock_monitor : measures period/high time of a divided clock,  |
// |   tracks lock and flags errors. Duty check: DIV_MON_DUTY_CHECK_EN.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module div_clock_monitor
   import div_mon_pkg::*;
#(
   parameter int EXP_HALF   = c_def_exp_half,
   parameter int CNT_W      = c_def_cnt_w,
   parameter int LOCK_COUNT = c_def_lock_count,
   parameter int TIMEOUT    = c_def_timeout
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_div,
   output logic             rise,
   output logic             fall,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             period_valid,
   output logic             locked,
   output logic             err
);
   localparam int                  c_good_w     = $clog2(LOCK_COUNT + 1);
   localparam logic [CNT_W-1:0]    c_cnt_max    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]    c_exp_period = CNT_W'(2 * EXP_HALF);
   localparam logic [CNT_W-1:0]    c_timeout    = CNT_W'(TIMEOUT);
   localparam logic [c_good_w-1:0] c_lock_count = c_good_w'(LOCK_COUNT);

   logic w_rise_now;
   logic w_duty_ok;

   edge_detect u_edge (
      .clk      (clk),
      .reset    (reset),
      .din      (clk_div),
      .rise_now (w_rise_now),
      .rise     (rise),
      .fall     (fall)
   );

`ifdef DIV_MON_DUTY_CHECK_EN
   localparam logic [CNT_W-1:0] c_exp_high = CNT_W'(EXP_HALF);

   logic [CNT_W-1:0] hcnt_q, hcnt_d;
   logic [CNT_W-1:0] high_time_q, high_time_d;

   // hcnt is non-zero exactly while the delayed clk_div is high, so it
   // doubles as the phase indicator and the fall detector here.
   always_comb begin
      hcnt_d      = hcnt_q;
      high_time_d = high_time_q;
      if (w_rise_now) begin
         hcnt_d = CNT_W'(1);
      end else if (!clk_div && hcnt_q != '0) begin
         high_time_d = hcnt_q;
         hcnt_d      = '0;
      end else if (hcnt_q != '0 && hcnt_q != c_cnt_max) begin
         hcnt_d = hcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hcnt_q      <= '0;
         high_time_q <= '0;
      end else begin
         hcnt_q      <= hcnt_d;
         high_time_q <= high_time_d;
      end
   end

   assign high_time = high_time_q;
   assign w_duty_ok = (high_time_q == c_exp_high);
`else
   assign high_time = '0;
   assign w_duty_ok = 1'b1;
`endif

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [c_good_w-1:0] good_cnt_q, good_cnt_d;
   logic [c_good_w-1:0] w_good_inc;
   logic [CNT_W-1:0]    period_q, period_d;
   logic                period_valid_q, period_valid_d;
   logic                locked_q, locked_d;
   logic                err_q, err_d;
   logic                w_good;

   assign w_good_inc = good_cnt_q + 1'b1;
   assign w_good     = (cnt_q == c_exp_period) && w_duty_ok;

   always_comb begin
      state_d        = state_q;
      cnt_d          = (cnt_q == c_cnt_max) ? cnt_q : cnt_q + 1'b1;
      good_cnt_d     = good_cnt_q;
      period_d       = period_q;
      period_valid_d = 1'b0;
      err_d          = 1'b0;
      if (w_rise_now) begin
         cnt_d = CNT_W'(1);
         if (state_q == ST_IDLE) begin
            state_d    = ST_ACQ;
            good_cnt_d = '0;
         end else begin
            period_d       = cnt_q;
            period_valid_d = 1'b1;
            if (!w_good) begin
               state_d    = ST_ACQ;
               good_cnt_d = '0;
               err_d      = 1'b1;
            end else if (state_q == ST_ACQ) begin
               good_cnt_d = w_good_inc;
               if (w_good_inc == c_lock_count) begin
                  state_d = ST_LOCK;
               end
            end
         end
      end else if (state_q != ST_IDLE && cnt_q == c_timeout) begin
         // A rise landing on the timeout count is judged above as a bad period.
         state_d    = ST_IDLE;
         good_cnt_d = '0;
         err_d      = 1'b1;
      end
      locked_d = (state_d == ST_LOCK);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         good_cnt_q     <= '0;
         period_q       <= '0;
         period_valid_q <= 1'b0;
         locked_q       <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         good_cnt_q     <= good_cnt_d;
         period_q       <= period_d;
         period_valid_q <= period_valid_d;
         locked_q       <= locked_d;
         err_q          <= err_d;
      end
   end

   assign period       = period_q;
   assign period_valid = period_valid_q;
   assign locked       = locked_q;
   assign err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_div_clock_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_div_clock_monitor : directed self-checking bench for            |
// |   div_clock_monitor (default parameters). Rev 1.0                  |
// +--------------------------------------------------------------------+
module tb_div_clock_monitor;
   import div_mon_pkg::*;

`ifdef DIV_MON_DUTY_CHECK_EN
   localparam bit DUTY = 1'b1;
`else
   localparam bit DUTY = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       clk_div;
   logic       rise, fall, period_valid, locked, err;
   logic [7:0] period, high_time;
   logic [3:0] flags;
   logic [7:0] ht_good, ht_bad;

   int tests_run    = 0;
   int tests_failed = 0;

   assign flags   = {rise, period_valid, err, locked};
   assign ht_good = DUTY ? 8'd2 : 8'd0;
   assign ht_bad  = DUTY ? 8'd3 : 8'd0;

   always #5 clk = ~clk;

   div_clock_monitor dut (
      .clk          (clk),
      .reset        (reset),
      .clk_div      (clk_div),
      .rise         (rise),
      .fall         (fall),
      .period       (period),
      .high_time    (high_time),
      .period_valid (period_valid),
      .locked       (locked),
      .err          (err)
   );

   task automatic step(input logic v);
      @(negedge clk);
      clk_div = v;
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input int h, input int l);
      for (int i = 0; i < h; i++) step(1'b1);
      for (int i = 0; i < l; i++) step(1'b0);
   endtask

   task automatic test_reset;
      reset   = 1'b1;
      clk_div = 1'b0;
      repeat (3) step(1'b0);
      tests_run++;
      if ({rise, fall, period_valid, err, locked} !== 5'b0 || period !== 8'd0 || high_time !== 8'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got pulses=%b period=%0d high=%0d expected all 0",
                  {rise, fall, period_valid, err, locked}, period, high_time);
      end
      reset = 1'b0;
   endtask

   task automatic test_ideal;
      step(1'b1);
      tests_run++;
      if (flags !== 4'b1000) begin
         tests_failed++;
         $display("FAIL ideal_first_rise: flags{rise,pv,err,lock}=%b expected 1000", flags);
      end
      step(1'b1);
      step(1'b0);
      tests_run++;
      if (fall !== 1'b1) begin
         tests_failed++;
         $display("FAIL ideal_fall: got %b expected 1", fall);
      end
      step(1'b0);
      for (int k = 1; k <= 4; k++) begin
         step(1'b1);
         tests_run++;
         if (flags !== {3'b110, k == 4} || period !== 8'd4 || high_time !== ht_good) begin
            tests_failed++;
            $display("FAIL ideal_period%0d: flags=%b period=%0d high=%0d expected flags=%b period=4 high=%0d",
                     k, flags, period, high_time, {3'b110, k == 4}, ht_good);
         end
         fill(1, 2);
      end
   endtask

   task automatic test_stretch;
      step(1'b1);
      tests_run++;
      if (flags !== 4'b1101 || period !== 8'd4) begin
         tests_failed++;
         $display("FAIL stretch_pre: flags=%b period=%0d expected 1101 period=4", flags, period);
      end
      fill(1, 3);
      step(1'b1);
      tests_run++;
      if (flags !== 4'b1110 || period !== 8'd5) begin
         tests_failed++;
         $display("FAIL stretch_bad: flags=%b period=%0d expected 1110 period=5", flags, period);
      end
      fill(1, 2);
      for (int k = 1; k <= 4; k++) begin
         step(1'b1);
         tests_run++;
         if (flags !== {3'b110, k == 4} || period !== 8'd4) begin
            tests_failed++;
            $display("FAIL stretch_relock%0d: flags=%b period=%0d expected %b period=4",
                     k, flags, period, {3'b110, k == 4});
         end
         fill(1, 2);
      end
   endtask

   task automatic test_stall;
      step(1'b1);
      tests_run++;
      if (flags !== 4'b1101) begin
         tests_failed++;
         $display("FAIL stall_last_rise: flags=%b expected 1101", flags);
      end
      for (int i = 1; i <= 16; i++) begin
         step(i == 1);
         tests_run++;
         if ({period_valid, err, locked} !== {1'b0, i == 16, i != 16}) begin
            tests_failed++;
            $display("FAIL stall_cycle%0d: {pv,err,lock}=%b expected %b",
                     i, {period_valid, err, locked}, {1'b0, i == 16, i != 16});
         end
      end
      fill(0, 2);
      tests_run++;
      if ({period_valid, err, locked} !== 3'b000 || dut.state_q !== ST_IDLE) begin
         tests_failed++;
         $display("FAIL stall_idle: {pv,err,lock}=%b state=%0d expected 000 state=0",
                  {period_valid, err, locked}, dut.state_q);
      end
      step(1'b1);
      tests_run++;
      if (flags !== 4'b1000) begin
         tests_failed++;
         $display("FAIL stall_restart: flags=%b expected 1000", flags);
      end
   endtask

   task automatic test_duty;
      fill(2, 1);
      for (int k = 1; k <= 6; k++) begin
         step(1'b1);
         tests_run++;
         if (flags !== {2'b11, DUTY, !DUTY && k >= 4} || period !== 8'd4 || high_time !== ht_bad) begin
            tests_failed++;
            $display("FAIL duty_period%0d: flags=%b period=%0d high=%0d expected %b period=4 high=%0d",
                     k, flags, period, high_time, {2'b11, DUTY, !DUTY && k >= 4}, ht_bad);
         end
         fill(2, 1);
      end
   endtask

   task automatic test_reset_mid;
      for (int k = 0; k < 6; k++) fill(2, 2);
      tests_run++;
      if (locked !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_mid_prelock: locked=%b expected 1", locked);
      end
      @(negedge clk);
      reset   = 1'b1;
      clk_div = 1'b1;
      @(posedge clk);
      #1;
      tests_run++;
      if ({rise, fall, period_valid, err, locked} !== 5'b0 || period !== 8'd0 ||
          high_time !== 8'd0 || dut.state_q !== ST_IDLE) begin
         tests_failed++;
         $display("FAIL rst_mid_outputs: pulses=%b period=%0d high=%0d state=%0d expected all 0",
                  {rise, fall, period_valid, err, locked}, period, high_time, dut.state_q);
      end
      reset = 1'b0;
      step(1'b0);
      tests_run++;
      if (flags !== 4'b0000 || period !== 8'd0) begin
         tests_failed++;
         $display("FAIL rst_mid_quiet: flags=%b period=%0d expected 0000 period=0", flags, period);
      end
      step(1'b1);
      tests_run++;
      if (flags !== 4'b1000) begin
         tests_failed++;
         $display("FAIL rst_mid_first_rise: flags=%b expected 1000", flags);
      end
      fill(1, 2);
      step(1'b1);
      tests_run++;
      if (flags !== 4'b1100 || period !== 8'd4) begin
         tests_failed++;
         $display("FAIL rst_mid_second_rise: flags=%b period=%0d expected 1100 period=4", flags, period);
      end
   endtask

   task automatic test_rise_at_timeout;
      fill(1, 14);
      step(1'b1);
      tests_run++;
      if (flags !== 4'b1110 || period !== 8'd16 || dut.state_q !== ST_ACQ) begin
         tests_failed++;
         $display("FAIL timeout_rise: flags=%b period=%0d state=%0d expected 1110 period=16 state=1",
                  flags, period, dut.state_q);
      end
      fill(1, 2);
      step(1'b1);
      tests_run++;
      if (flags !== 4'b1100 || period !== 8'd4) begin
         tests_failed++;
         $display("FAIL timeout_after: flags=%b period=%0d expected 1100 period=4", flags, period);
      end
   endtask

   initial begin
      test_reset();
      test_ideal();
      test_stretch();
      test_stall();
      test_duty();
      test_reset_mid();
      test_rise_at_timeout();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/div_clock_monitor.md
# div_clock_monitor

Checks a divided clock produced inside the `clk` domain, such as the output of the divide-by-4 clock divider, from the receiving side. It finds the clock's edges, measures its period and high time in `clk` cycles, and declares lock after a run of consecutive correct periods. It flags wrong periods and a stalled divided clock. It sits beside the divider in the game top level and feeds status LEDs and debug logic.

## Interface
Parameters:
- `EXP_HALF`, default 2: expected half-period in `clk` cycles. Expected period is 2·`EXP_HALF`.
- `CNT_W`, default 8: width of the counter and of the measurement outputs.
- `LOCK_COUNT`, default 4: number of consecutive good periods needed to lock.
- `TIMEOUT`, default 16: number of `clk` cycles without a rising edge that counts as a stall. Must satisfy 2·`EXP_HALF` < `TIMEOUT` ≤ 2^`CNT_W`−1.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high reset.
- `clk_div`, in, 1: divided clock under test, generated from `clk`.
- `rise`, out, 1: one-cycle pulse for each rising edge of `clk_div`.
- `fall`, out, 1: one-cycle pulse for each falling edge of `clk_div`.
- `period`, out, `CNT_W`: most recent rise-to-rise period, in `clk` cycles.
- `high_time`, out, `CNT_W`: most recent high duration, in `clk` cycles.
- `period_valid`, out, 1: one-cycle pulse when `period` updates.
- `locked`, out, 1: level; high while in LOCK.
- `err`, out, 1: one-cycle pulse on a bad period, bad duty cycle, or timeout.

## Operation
- Edge detection:
  - `clk_div` is registered into `d1` every cycle.
  - A rise is `clk_div & ~d1`; a fall is `~clk_div & d1`.
- Period counter `cnt`:
  - Loaded with 1 on a rise.
  - Otherwise increments, saturating at 2^`CNT_W`−1.
- High counter `hcnt`:
  - Loaded with 1 on a rise.
  - Increments while `d1` is high.
  - Latched into `high_time` on a fall.
- A rise in any state other than IDLE latches `period` ← `cnt` and pulses `period_valid`.
- A period is good when `period` = 2·`EXP_HALF`, and, with the duty check compiled in, the latched `high_time` = `EXP_HALF`.
- State machine:
  - **IDLE** (reset state): on the first rise → ACQ, clear `good_cnt`. No `period_valid` is produced for this rise.
  - **ACQ**:
    - Good period → `good_cnt`+1; on reaching `LOCK_COUNT` → LOCK.
    - Bad period → `good_cnt` ← 0, pulse `err`, stay in ACQ.
  - **LOCK**: good period → stay. Bad period → ACQ, `good_cnt` ← 0, pulse `err`.
  - **Timeout**: in ACQ or LOCK, if `cnt` = `TIMEOUT` and there is no rise this cycle → IDLE, pulse `err`.
- Simultaneous events:
  - A rise in the same cycle as `cnt` = `TIMEOUT` is handled as a bad period, not as a timeout.
  - Reset has priority over every other event.
- A constant `clk_div` never produces `period_valid`.
- Reset mid-operation returns the block to IDLE, and all measurement history is discarded.

## Timing
- Reset values:
  - `rise`, `fall`, `period_valid`, `locked`, `err` = 0.
  - `period`, `high_time` = 0.
  - `d1`, `cnt`, `hcnt`, `good_cnt` = 0.
- All outputs are registered.
- Latency:
  - `rise` and `fall` appear 1 cycle after the `clk` edge at which `clk_div` is first sampled at its new level.
  - `period`, `period_valid` and `err` update in the same cycle as the corresponding `rise`.
  - `locked` rises in the same cycle as the `period_valid` of the `LOCK_COUNT`-th good period.
  - `locked` falls in the same cycle as the `err` that caused the exit.
- For an ideal divide-by-4 clock, `rise` pulses every 4 cycles and `period` = 4.

## Configuration
- Macro: `DIV_MON_DUTY_CHECK_EN`.
- Defined: `high_time` is measured, and a period counts as good only if both period and high time match.
- Undefined: the `hcnt` logic is removed, `high_time` is tied to 0, and only the period is checked.

## Structure
- Package `div_mon_pkg` holds:
  - the state encoding (IDLE, ACQ, LOCK);
  - the default parameter constants.
- Sub-module `edge_detect` holds the `d1` register and the `rise`/`fall` logic, and is reusable for button inputs elsewhere.
- The counters and the state machine stay in `div_clock_monitor`.

## Test plan
1. **Ideal divide-by-4 clock** (2 high, 2 low), defaults: first rise → ACQ. Four `period_valid` pulses with `period`=4 follow. `locked` = 1 on the 4th pulse; `err` stays 0.
2. **Locked, then one low phase stretched to 3 cycles**: `period`=5 and `err` pulses; `locked` drops in the same cycle. Re-lock after 4 more good periods.
3. **Locked, then `clk_div` held low**: 16 cycles after the last rise, `err` pulses, the block returns to IDLE and `locked` = 0. No `period_valid` fires.
4. **Duty error, 3 high / 1 low**:
   - With `DIV_MON_DUTY_CHECK_EN`: `high_time`=3, `err` on every period, never locks.
   - Without the macro: locks normally.
5. **Reset asserted for 1 cycle while locked**: the next cycle shows all outputs at their reset values and the state is IDLE. The next rise produces no `period_valid`.
6. **Rise coinciding with `cnt`=`TIMEOUT`** (high 2, low 14): `period`=16, `err` pulse, state becomes ACQ rather than IDLE.
